// File: rtl/or_reduce_pipe.sv
// Pipelined N-input bitwise OR reducer with per-channel masking.
// It also tracks valid samples and has a sticky accumulate mode.
// Stage 1 registers the OR of each group of three masked channels.
// Stage 2 merges those group results and updates the accumulator and Output.
// The latency from a sample to its Output is fixed at two cycles.
module or_reduce_pipe #(
  parameter int          UUID       = 0,
  parameter string       NAME       = "",
  parameter int unsigned NUM_INPUTS = 7,
  parameter int unsigned BIT_WIDTH  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_INPUTS*BIT_WIDTH-1:0] Input,
  input  logic [NUM_INPUTS-1:0]           Mask,
  input  logic                            In_valid,
  input  logic                            Mode,
  input  logic                            Clear,
  output logic [BIT_WIDTH-1:0]            Output,
  output logic                            Out_valid,
  output logic                            Any
);

  localparam int unsigned NumGroups = (NUM_INPUTS + 2) / 3;
  localparam int unsigned NumPadded = NumGroups * 3;

  // Reject illegal sizes at elaboration.
  if (NUM_INPUTS < 2 || NUM_INPUTS > 64 || BIT_WIDTH < 1 || BIT_WIDTH > 64) begin : g_param_err
    $error("or_reduce_pipe: NUM_INPUTS must be 2..64 and BIT_WIDTH 1..64");
  end

  logic [NumPadded-1:0][BIT_WIDTH-1:0] chan_pad;
  logic [NumGroups-1:0][BIT_WIDTH-1:0] part_d, part_q;
  logic                                v1_q, mode1_q, clr1_q;

  logic [BIT_WIDTH-1:0] red;
  logic [BIT_WIDTH-1:0] acc_d, acc_q;
  logic [BIT_WIDTH-1:0] out_d, out_q;
  logic                 out_valid_d, out_valid_q;
  logic                 any_d, any_q;
  logic                 last_sticky_d, last_sticky_q;

  // Zero the masked channels and pad the last group of three with zero channels.
  always_comb begin
    chan_pad = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      chan_pad[k] = Mask[k] ? Input[k*BIT_WIDTH +: BIT_WIDTH] : '0;
    end
  end

  // Compute one partial OR for each group of three channels.
  always_comb begin
    part_d = '0;
    for (int unsigned g = 0; g < NumGroups; g++) begin
      part_d[g] = chan_pad[3*g] | chan_pad[3*g+1] | chan_pad[3*g+2];
    end
  end

  // Stage 1 registers. Partials and Mode are captured only for valid samples.
  // Clear is captured on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      part_q  <= '0;
      v1_q    <= 1'b0;
      mode1_q <= 1'b0;
      clr1_q  <= 1'b0;
    end else begin
      v1_q   <= In_valid;
      clr1_q <= Clear;
      if (In_valid) begin
        part_q  <= part_d;
        mode1_q <= Mode;
      end
    end
  end

  // Stage 2 next state. The clear is applied before a same-cycle sample is accumulated.
  always_comb begin
    red = '0;
    for (int unsigned g = 0; g < NumGroups; g++) begin
      red = red | part_q[g];
    end
    acc_d         = (clr1_q ? '0 : acc_q) | (v1_q ? red : '0);
    out_d         = out_q;
    out_valid_d   = 1'b0;
    last_sticky_d = last_sticky_q;
    if (v1_q) begin
      out_d         = mode1_q ? acc_d : red;
      out_valid_d   = 1'b1;
      last_sticky_d = mode1_q;
    end else if (clr1_q && last_sticky_q) begin
      // A lone clear zeroes the Output only when the Output is showing the sticky accumulator.
      out_d = '0;
    end
    any_d = |out_d;
  end

  // Stage 2 registers. The accumulator is updated on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      any_q         <= 1'b0;
      last_sticky_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      any_q         <= any_d;
      last_sticky_q <= last_sticky_d;
    end
  end

  assign Output    = out_q;
  assign Out_valid = out_valid_q;
  assign Any       = any_q;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Testbench for or_reduce_pipe. It has three instances: 7x8, 2x1 and 64x64.
// Each valid sample pushes its expected Output into a queue, tagged with the cycle it is due.
// The monitor pops the queue when Out_valid is due and checks Output, Any and the pulse timing.
module tb_or_reduce_pipe;

  typedef struct {
    int          due;
    logic [63:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // Instance A: 7 channels of 8 bits.
  logic [55:0] in_a = '0;
  logic [6:0]  mask_a = '0;
  logic        va = 1'b0, mode_a = 1'b0, clr_a = 1'b0;
  logic [7:0]  out_a;
  logic        ova, any_a;
  logic [7:0]  acc_m = '0;

  // Instance B: 2 channels of 1 bit.
  logic [1:0]  in_b = '0;
  logic [1:0]  mask_b = '0;
  logic        vb = 1'b0;
  logic [0:0]  out_b;
  logic        ovb, any_b;

  // Instance C: 64 channels of 64 bits.
  logic [4095:0] in_c = '0;
  logic [63:0]   mask_c = '0;
  logic          vc = 1'b0;
  logic [63:0]   out_c;
  logic          ovc, any_c;

  logic mode_bc = 1'b0, clr_bc = 1'b0;

  or_reduce_pipe #(.UUID(1), .NAME("a"), .NUM_INPUTS(7), .BIT_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .Input(in_a), .Mask(mask_a), .In_valid(va), .Mode(mode_a),
    .Clear(clr_a), .Output(out_a), .Out_valid(ova), .Any(any_a)
  );

  or_reduce_pipe #(.UUID(2), .NAME("b"), .NUM_INPUTS(2), .BIT_WIDTH(1)) u_b (
    .clk(clk), .rst(rst), .Input(in_b), .Mask(mask_b), .In_valid(vb), .Mode(mode_bc),
    .Clear(clr_bc), .Output(out_b), .Out_valid(ovb), .Any(any_b)
  );

  or_reduce_pipe #(.UUID(3), .NAME("c"), .NUM_INPUTS(64), .BIT_WIDTH(64)) u_c (
    .clk(clk), .rst(rst), .Input(in_c), .Mask(mask_c), .In_valid(vc), .Mode(mode_bc),
    .Clear(clr_bc), .Output(out_c), .Out_valid(ovc), .Any(any_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on instance A. For a valid sample, the model computes the expected Output.
  task automatic drive_a(input logic v, input logic [55:0] data, input logic [6:0] mask,
                         input logic mode, input logic clr);
    logic [7:0] r;
    exp_t       e;
    in_a = data; mask_a = mask; va = v; mode_a = mode; clr_a = clr;
    r = '0;
    for (int k = 0; k < 7; k++) if (mask[k]) r = r | data[k*8 +: 8];
    if (v) begin
      acc_m = (clr ? 8'h00 : acc_m) | r;
      e.due = cyc + 2;
      e.val = {56'h0, (mode ? acc_m : r)};
      qa.push_back(e);
    end else if (clr) begin
      acc_m = '0;
    end
    tick();
  endtask

  task automatic idle(input int n);
    va = 1'b0; clr_a = 1'b0; vb = 1'b0; vc = 1'b0;
    repeat (n) tick();
  endtask

  // Monitor the outputs at the negative edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (qa.size() != 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        check("a_valid", {63'h0, ova}, 64'h1);
        check("a_out", {56'h0, out_a}, e.val);
        check("a_any", {63'h0, any_a}, {63'h0, |e.val});
      end else begin
        check("a_novalid", {63'h0, ova}, 64'h0);
      end
      if (qb.size() != 0 && qb[0].due == cyc) begin
        e = qb.pop_front();
        check("b_valid", {63'h0, ovb}, 64'h1);
        check("b_out", {63'h0, out_b}, e.val);
        check("b_any", {63'h0, any_b}, {63'h0, |e.val});
      end else begin
        check("b_novalid", {63'h0, ovb}, 64'h0);
      end
      if (qc.size() != 0 && qc[0].due == cyc) begin
        e = qc.pop_front();
        check("c_valid", {63'h0, ovc}, 64'h1);
        check("c_out", out_c, e.val);
        check("c_any", {63'h0, any_c}, {63'h0, |e.val});
      end else begin
        check("c_novalid", {63'h0, ovc}, 64'h0);
      end
    end
  end

  initial begin
    exp_t e;
    logic [63:0] m;
    logic [1:0]  mb;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_out", {56'h0, out_a}, 64'h0);
    check("rst_valid", {63'h0, ova}, 64'h0);
    check("rst_any", {63'h0, any_a}, 64'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Pass sample with ch0 = 0x01 and ch6 = 0x80 produces 0x81; the Output then holds.
    drive_a(1'b1, 56'h80_0000_0000_0001, 7'h7F, 1'b0, 1'b0);
    idle(4);
    check("hold_out", {56'h0, out_a}, 64'h81);
    check("hold_any", {63'h0, any_a}, 64'h1);

    // The same sample with ch0 and ch6 masked produces 0.
    drive_a(1'b1, 56'h80_0000_0000_0001, 7'h3E, 1'b0, 1'b0);
    idle(3);

    // Sticky accumulation, then a lone clear, then a clear together with a sample.
    drive_a(1'b1, 56'h01 << 24, 7'h7F, 1'b1, 1'b1);
    drive_a(1'b1, 56'h04 << 24, 7'h7F, 1'b1, 1'b0);
    drive_a(1'b1, 56'h10 << 24, 7'h7F, 1'b1, 1'b0);
    drive_a(1'b0, 56'h0, 7'h7F, 1'b0, 1'b1);
    idle(2);
    check("sticky_clr_out", {56'h0, out_a}, 64'h0);
    check("sticky_clr_any", {63'h0, any_a}, 64'h0);
    drive_a(1'b1, 56'h20 << 16, 7'h7F, 1'b1, 1'b1);
    idle(3);

    // A lone clear after a pass sample leaves the Output unchanged.
    drive_a(1'b1, 56'h04, 7'h7F, 1'b0, 1'b0);
    idle(2);
    drive_a(1'b0, 56'h0, 7'h7F, 1'b0, 1'b1);
    idle(3);
    check("pass_clr_out", {56'h0, out_a}, 64'h04);

    // Back-to-back samples with alternating Mode produce 0x02, 0x0A, 0x01.
    drive_a(1'b1, 56'h02 << 40, 7'h7F, 1'b0, 1'b1);
    drive_a(1'b1, 56'h08 << 8, 7'h7F, 1'b1, 1'b0);
    drive_a(1'b1, 56'h01 << 32, 7'h7F, 1'b0, 1'b0);
    idle(3);

    // Reset while a sample is in flight; a following sticky sample shows the accumulator is clear.
    drive_a(1'b1, 56'h10, 7'h7F, 1'b0, 1'b0);
    va = 1'b0;
    rst = 1'b1;
    qa.delete();
    acc_m = '0;
    tick();
    rst = 1'b0;
    check("rst_fly_out", {56'h0, out_a}, 64'h0);
    idle(2);
    check("rst_fly_out2", {56'h0, out_a}, 64'h0);
    drive_a(1'b1, 56'h40 << 48, 7'h7F, 1'b1, 1'b0);
    idle(3);

    // 2x1 instance: one-hot sweep under every mask pattern.
    for (int k = 0; k < 2; k++) begin
      for (int mi = 0; mi < 4; mi++) begin
        mb = mi[1:0];
        in_b = 2'b01 << k;
        mask_b = mb;
        vb = 1'b1;
        e.due = cyc + 2;
        e.val = {63'h0, mb[k]};
        qb.push_back(e);
        tick();
      end
    end
    idle(3);

    // 64x64 instance: one-hot sweep over every channel with random masks.
    for (int k = 0; k < 64; k++) begin
      m = {$urandom, $urandom};
      if (k == 0) m[k] = 1'b1;
      if (k == 63) m[k] = 1'b0;
      in_c = '0;
      in_c[k*64 +: 64] = 64'h1 << k;
      mask_c = m;
      vc = 1'b1;
      e.due = cyc + 2;
      e.val = m[k] ? (64'h1 << k) : 64'h0;
      qc.push_back(e);
      tick();
    end
    idle(4);

    check("qa_drained", 64'(qa.size()), 64'h0);
    check("qb_drained", 64'(qb.size()), 64'h0);
    check("qc_drained", 64'(qc.size()), 64'h0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
